// File: rtl/phone_digit_scroller.sv
// Scrolling 4-digit window fed by a paced valid/ready digit stream, scanned
// onto a common-anode seven-segment display; pulses num_done per phone number.
module phone_digit_scroller #(
    parameter int unsigned REFRESH_DIV = 16,
    parameter int unsigned SCROLL_DIV  = 64,
    parameter int unsigned PHONE_LEN   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    output logic        digit_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] window,
    output logic        num_done
);

    localparam int unsigned SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned RCW = $clog2(REFRESH_DIV);

    localparam logic [SCW-1:0] SCROLL_LOAD = SCW'(SCROLL_DIV - 1);
    localparam logic [RCW-1:0] REF_LAST    = RCW'(REFRESH_DIV - 1);
    localparam logic [3:0]     DIG_LAST    = 4'(PHONE_LEN - 1);

    logic [SCW-1:0] scroll_cnt;
    logic [RCW-1:0] ref_cnt;
    logic [1:0]     sel;
    logic [3:0]     dig_cnt;
    logic [3:0]     nib;
    logic [6:0]     seg_next;
    logic           accept;

    assign digit_ready = (scroll_cnt == '0);
    assign accept      = digit_valid & digit_ready;

    always_comb begin
        nib      = window[{sel, 2'b00} +: 4];
        seg_next = 7'b1111111;
        case (nib)
            4'h0:    seg_next = 7'b1000000;
            4'h1:    seg_next = 7'b1111001;
            4'h2:    seg_next = 7'b0100100;
            4'h3:    seg_next = 7'b0110000;
            4'h4:    seg_next = 7'b0011001;
            4'h5:    seg_next = 7'b0010010;
            4'h6:    seg_next = 7'b0000010;
            4'h7:    seg_next = 7'b1111000;
            4'h8:    seg_next = 7'b0000000;
            4'h9:    seg_next = 7'b0010000;
            4'hF:    seg_next = 7'b1111111;
            default: seg_next = 7'b0111111; // non-BCD codes show a dash
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window     <= '1;
            scroll_cnt <= '0;
            dig_cnt    <= '0;
            num_done   <= 1'b0;
            ref_cnt    <= '0;
            sel        <= '0;
            an         <= '1;
            seg        <= '1;
        end else begin
            num_done <= 1'b0;
            if (accept) begin
                window     <= {window[11:0], digit};
                scroll_cnt <= SCROLL_LOAD;
                if (dig_cnt == DIG_LAST) begin
                    dig_cnt  <= '0;
                    num_done <= 1'b1;
                end else begin
                    dig_cnt <= dig_cnt + 4'd1;
                end
            end else if (scroll_cnt != '0) begin
                scroll_cnt <= scroll_cnt - 1'b1;
            end

            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                sel     <= sel + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            // Display registers sample the pre-edge sel/window, so they lag by one clock.
            an  <= ~(4'b0001 << sel);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_phone_digit_scroller.sv
// Directed self-checking bench for phone_digit_scroller with default parameters.
module tb_phone_digit_scroller;

    logic        clk = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] window;
    logic        num_done;

    int compared = 0;
    int fails    = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_acc = 0;

    phone_digit_scroller #(
        .REFRESH_DIV(16),
        .SCROLL_DIV (64),
        .PHONE_LEN  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_valid(digit_valid),
        .digit      (digit),
        .digit_ready(digit_ready),
        .seg        (seg),
        .an         (an),
        .window     (window),
        .num_done   (num_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (num_done === 1'b1) pulses <= pulses + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        int n;
        digit       = d;
        digit_valid = 1'b1;
        n = 0;
        while (digit_ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            compared++;
            fails++;
            $error("FAIL ready_timeout: observed %0d expected <300", n);
        end
        step();
        last_acc = cyc;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_an"},     16'(an),          16'hF);
        chk({tag, "_seg"},    16'(seg),         16'h7F);
        chk({tag, "_window"}, window,           16'hFFFF);
        chk({tag, "_ready"},  16'(digit_ready), 16'h1);
        chk({tag, "_done"},   16'(num_done),    16'h0);
    endtask

    logic [3:0] seq [0:9];
    logic [3:0] scan_an  [0:3];
    logic [6:0] scan_seg [0:3];

    initial begin
        int n;
        int prev;
        int p0;
        seq = '{4'd7, 4'd2, 4'd8, 4'd7, 4'd9, 4'd0, 4'd9, 4'd4, 4'd1, 4'd0};
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_seg = '{7'b0010010, 7'b1000000, 7'b0111111, 7'b1111111};

        // T1 reset
        reset = 1'b1;
        digit_valid = 1'b0;
        digit = 4'h0;
        step(); step(); step();
        check_reset_state("t1");
        reset = 1'b0;

        // T2 single accept and ready pacing
        send(4'h7);
        digit_valid = 1'b0;
        chk("t2_window", window, 16'hFFF7);
        n = 0;
        while (digit_ready !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("t2_ready_low_clks", 16'(n), 16'd63);
        n = 0;
        while (an !== 4'b1110 && n < 200) begin
            n++;
            step();
        end
        chk("t2_an", 16'(an), 16'hE);
        chk("t2_seg", 16'(seg), 16'h78);

        // T3/T4 continuous stream from a clean state
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            prev = last_acc;
            send(seq[i]);
            if (i > 0) chk($sformatf("t3_gap%0d", i), 16'(last_acc - prev), 16'd64);
            if (i == 8) chk("t4_no_early_pulse", 16'(pulses - p0), 16'd0);
        end
        chk("t3_window", window, 16'h9410);
        chk("t4_done_after_10th", 16'(num_done), 16'h1);
        step();
        chk("t4_done_one_cycle", 16'(num_done), 16'h0);
        send(4'h7);
        chk("t4_window_11th", window, 16'h4107);
        step();
        chk("t4_pulse_count", 16'(pulses - p0), 16'd1);

        // T5 scan/decode with window FA05
        send(4'hF);
        send(4'hA);
        send(4'h0);
        send(4'h5);
        digit_valid = 1'b0;
        chk("t5_window", window, 16'hFA05);
        n = 0;
        while (an === 4'b1110 && n < 200) begin
            n++;
            step();
        end
        n = 0;
        while (an !== 4'b1110 && n < 200) begin
            n++;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_an%0d", k), 16'(an), 16'(scan_an[k]));
            chk($sformatf("t5_seg%0d", k), 16'(seg), 16'(scan_seg[k]));
            n = 0;
            while (an === scan_an[k] && n < 100) begin
                n++;
                step();
            end
            chk($sformatf("t5_hold%0d", k), 16'(n), 16'd16);
        end

        // T6 reset mid-operation
        for (int i = 0; i < 4; i++) send(seq[i]);
        digit_valid = 1'b0;
        step(); step(); step(); step();
        chk("t6_busy_before_reset", 16'(digit_ready), 16'h0);
        reset = 1'b1;
        step();
        check_reset_state("t6");
        reset = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 9; i++) send(seq[i]);
        chk("t6_no_early_pulse", 16'(pulses - p0), 16'd0);
        send(seq[9]);
        chk("t6_done_after_10th", 16'(num_done), 16'h1);
        chk("t6_window", window, 16'h9410);
        digit_valid = 1'b0;
        step();
        chk("t6_done_one_cycle", 16'(num_done), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
